// File: rtl/ipram_loader_pkg.sv
// Shared types and helpers for the boot-loaded instruction RAM.
package ipram_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SLOT_W = 3;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } ipram_state_e;

  // Byte index -> physical byte slot inside a word; lane 0 maps to the MSB slot.
  function automatic logic [SLOT_W-1:0] lane_slot(input logic [15:0] byte_idx,
                                                  input int unsigned lanes);
    logic [SLOT_W-1:0] lane;
    lane = SLOT_W'(byte_idx & 16'(lanes - 1));
    return SLOT_W'(lanes - 1) - lane;
  endfunction

endpackage

// File: rtl/ipram_bank.sv
// Word-organised instruction storage with per-lane active-low write enables.
// Write is synchronous; the read port is combinational so the top can register
// the selected byte directly. Swap point for a hard memory macro.
module ipram_bank #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WA_W  = 10
) (
  input  logic                 clk,
  input  logic                 cs_n,
  input  logic [LANES-1:0]     we_n,
  input  logic [WA_W-1:0]      addr,
  input  logic [8*LANES-1:0]   wdata,
  output logic [8*LANES-1:0]   rdata_c
);

  localparam int unsigned WORDS = 1 << WA_W;

  logic [8*LANES-1:0] mem [WORDS];

  // Byte-lane writes while selected; contents are never cleared.
  always_ff @(posedge clk) begin
    if (!cs_n) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (!we_n[l]) begin
          mem[addr][8*l +: 8] <= wdata[8*l +: 8];
        end
      end
    end
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/ipram_loader.sv
// Boot-loaded instruction RAM: fills itself from a valid/ready byte stream after
// reset or on reload, then serves 1-cycle-latency byte reads.
// Optional macro IPRAM_WRITE_EN adds a RUN-time byte write port (we, wdata).
module ipram_loader
  import ipram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned LANES      = 4,
  parameter int unsigned LOAD_BYTES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic              reload,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
`ifdef IPRAM_WRITE_EN
  input  logic              we,
  input  logic [7:0]        wdata,
`endif
  output logic [7:0]        dout,
  output logic              dout_valid,
  output logic              loaded
);

  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned WA_W   = ADDR_W - LANE_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(LOAD_BYTES);

  ipram_state_e        state_q, state_d;
  logic [CNT_W-1:0]    count_q;

  logic                accept_c;
  logic                clear_c;
  logic                rd_c;
  logic                in_range_c;
  logic [SLOT_W-1:0]   rd_slot_c;
  logic [7:0]          rd_byte_c;

  logic                bank_cs_n_c;
  logic [LANES-1:0]    bank_we_n_c;
  logic [ADDR_W-1:0]   bank_byte_addr_c;
  logic [7:0]          bank_wbyte_c;
  logic [WA_W-1:0]     bank_word_c;
  logic [8*LANES-1:0]  bank_rdata_c;

  assign in_range_c  = {1'b0, addr} < LIMIT;
  assign rd_slot_c   = lane_slot(16'(addr), LANES);
  assign bank_word_c = WA_W'(bank_byte_addr_c >> LANE_W);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, load/run request decode and bank port steering.
  always_comb begin
    state_d          = state_q;
    accept_c         = 1'b0;
    clear_c          = 1'b0;
    rd_c             = 1'b0;
    bank_cs_n_c      = 1'b1;
    bank_we_n_c      = '1;
    bank_byte_addr_c = addr;
    bank_wbyte_c     = load_data;
    case (state_q)
      ST_LOAD: begin
        if (load_valid) begin
          accept_c         = 1'b1;
          bank_cs_n_c      = 1'b0;
          bank_byte_addr_c = count_q[ADDR_W-1:0];
          bank_we_n_c      = ~(LANES'(1) << lane_slot(16'(count_q[ADDR_W-1:0]), LANES));
          if (count_q == LAST_IDX) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_d = ST_LOAD;
          clear_c = 1'b1;
        end else if (ce) begin
`ifdef IPRAM_WRITE_EN
          if (we) begin
            if (in_range_c) begin
              bank_cs_n_c  = 1'b0;
              bank_we_n_c  = ~(LANES'(1) << rd_slot_c);
              bank_wbyte_c = wdata;
            end
          end else begin
            rd_c = 1'b1;
          end
`else
          rd_c = 1'b1;
`endif
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Load byte counter; restarts on reload or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_c) begin
      count_q <= '0;
    end else if (accept_c) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Pick the addressed byte out of the word read.
  always_comb begin
    rd_byte_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (rd_slot_c == SLOT_W'(l)) begin
        rd_byte_c = bank_rdata_c[8*l +: 8];
      end
    end
  end

  // Registered outputs; dout only moves on a read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      loaded     <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      loaded     <= (state_d == ST_RUN);
      load_ready <= (state_d == ST_LOAD);
      dout_valid <= rd_c;
      if (rd_c) begin
        dout <= in_range_c ? rd_byte_c : 8'h00;
      end
    end
  end

  ipram_bank #(
    .LANES (LANES),
    .WA_W  (WA_W)
  ) u_bank (
    .clk     (clk),
    .cs_n    (bank_cs_n_c),
    .we_n    (bank_we_n_c),
    .addr    (bank_word_c),
    .wdata   ({LANES{bank_wbyte_c}}),
    .rdata_c (bank_rdata_c)
  );

endmodule

// File: tb/tb_ipram_loader.sv
// Bench for ipram_loader: a full-size instance (A) and a small one (B, 256 bytes,
// 16-byte load pass) checked against byte-array reference images.
module tb_ipram_loader;

  localparam int unsigned A_LB = 4096;
  localparam int unsigned B_LB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_lv, a_lr, a_reload, a_ce, a_dv, a_loaded;
  logic [7:0] a_ld, a_dout;
  logic [11:0] a_addr;
  logic       b_reset, b_lv, b_lr, b_reload, b_ce, b_dv, b_loaded;
  logic [7:0] b_ld, b_dout;
  logic [7:0] b_addr;
`ifdef IPRAM_WRITE_EN
  logic       a_we, b_we;
  logic [7:0] a_wd, b_wd;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] ref_a [A_LB];
  logic [7:0] ref_b [256];
  logic [7:0] exp_a_dout, exp_b_dout;

  ipram_loader #(.ADDR_W(12), .LANES(4), .LOAD_BYTES(A_LB)) u_a (
    .clk(clk), .reset(a_reset), .load_valid(a_lv), .load_data(a_ld), .load_ready(a_lr),
    .reload(a_reload), .ce(a_ce), .addr(a_addr),
`ifdef IPRAM_WRITE_EN
    .we(a_we), .wdata(a_wd),
`endif
    .dout(a_dout), .dout_valid(a_dv), .loaded(a_loaded));

  ipram_loader #(.ADDR_W(8), .LANES(4), .LOAD_BYTES(B_LB)) u_b (
    .clk(clk), .reset(b_reset), .load_valid(b_lv), .load_data(b_ld), .load_ready(b_lr),
    .reload(b_reload), .ce(b_ce), .addr(b_addr),
`ifdef IPRAM_WRITE_EN
    .we(b_we), .wdata(b_wd),
`endif
    .dout(b_dout), .dout_valid(b_dv), .loaded(b_loaded));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read on A: model returns the stored byte in range, 0 beyond the pass.
  task automatic a_read(input logic [11:0] ad, input string tag);
    a_ce = 1'b1; a_addr = ad;
    tick();
    a_ce = 1'b0;
    exp_a_dout = (32'(ad) < A_LB) ? ref_a[ad] : 8'h00;
    chk({tag, "_dv"}, 32'(a_dv), 32'(1));
    chk({tag, "_dout"}, 32'(a_dout), 32'(exp_a_dout));
  endtask

  task automatic b_read(input logic [7:0] ad, input string tag);
    b_ce = 1'b1; b_addr = ad;
    tick();
    b_ce = 1'b0;
    exp_b_dout = (32'(ad) < B_LB) ? ref_b[ad] : 8'h00;
    chk({tag, "_dv"}, 32'(b_dv), 32'(1));
    chk({tag, "_dout"}, 32'(b_dout), 32'(exp_b_dout));
  endtask

  // Random mix of reads and idle cycles on A.
  task automatic a_random_reads(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(3) != 0) begin
        a_read(12'($urandom), tag);
      end else begin
        a_addr = 12'($urandom);
        tick();
        chk({tag, "_idle_dv"}, 32'(a_dv), 32'(0));
        chk({tag, "_hold"}, 32'(a_dout), 32'(exp_a_dout));
      end
    end
  endtask

  // Full load pass on A. mode 0: data=index, always valid; 1: fixed byte, valid
  // every other cycle; 2: random data, random valid, stray ce/reload.
  task automatic a_pass(input int mode, input logic [7:0] fixed);
    int acc = 0;
    int cyc = 0;
    while (acc < int'(A_LB)) begin
      logic       v;
      logic [7:0] d;
      case (mode)
        0:       begin v = 1'b1; d = 8'(acc); end
        1:       begin v = (cyc % 2 == 0); d = fixed; end
        default: begin v = ($urandom_range(3) != 0); d = 8'($urandom); end
      endcase
      a_lv = v; a_ld = d; a_addr = 12'($urandom);
      a_ce     = (mode == 2) ? 1'($urandom) : 1'b0;
      a_reload = (mode == 2) ? ($urandom_range(15) == 0) : 1'b0;
      tick();
      cyc++;
      if (v) begin
        ref_a[acc] = d;
        acc++;
      end
      if (cyc == 1) chk("a_pass_ready", 32'(a_lr), 32'(1));
      if (cyc % 700 == 0) chk("a_pass_no_dv", 32'(a_dv), 32'(0));
      if (v && (acc == int'(A_LB) - 100 || acc == int'(A_LB) - 1))
        chk("a_pass_not_loaded", 32'(a_loaded), 32'(0));
    end
    a_lv = 1'b0; a_ce = 1'b0; a_reload = 1'b0;
    chk("a_pass_loaded", 32'(a_loaded), 32'(1));
    chk("a_pass_ready_low", 32'(a_lr), 32'(0));
    chk("a_pass_dout_held", 32'(a_dout), 32'(exp_a_dout));
  endtask

  initial begin
    a_reset = 1'b1; a_lv = 1'b0; a_ld = '0; a_reload = 1'b0; a_ce = 1'b0; a_addr = '0;
    b_reset = 1'b1; b_lv = 1'b0; b_ld = '0; b_reload = 1'b0; b_ce = 1'b0; b_addr = '0;
`ifdef IPRAM_WRITE_EN
    a_we = 1'b0; a_wd = '0; b_we = 1'b0; b_wd = '0;
`endif
    exp_a_dout = 8'h00; exp_b_dout = 8'h00;
    tick(); tick();
    chk("rst_a_dout", 32'(a_dout), 32'(0));
    chk("rst_a_dv", 32'(a_dv), 32'(0));
    chk("rst_a_loaded", 32'(a_loaded), 32'(0));
    chk("rst_b_dout", 32'(b_dout), 32'(0));
    a_reset = 1'b0; b_reset = 1'b0;
    tick();
    chk("rel_a_ready", 32'(a_lr), 32'(1));
    chk("rel_b_ready", 32'(b_lr), 32'(1));

    // Index-valued pass, then the canonical read.
    a_pass(0, 8'h00);
    a_read(12'h005, "t1_rd5");
    chk("t1_val5", 32'(a_dout), 32'h05);
    tick();
    chk("t1_idle_dv", 32'(a_dv), 32'(0));
    chk("t1_hold", 32'(a_dout), 32'h05);
    a_random_reads(30, "t1_rand");

    // Reload collides with a read: reload wins.
    a_reload = 1'b1; a_ce = 1'b1; a_addr = 12'h003;
    tick();
    a_reload = 1'b0; a_ce = 1'b0;
    chk("t5_reload_dv", 32'(a_dv), 32'(0));
    chk("t5_reload_loaded", 32'(a_loaded), 32'(0));
    chk("t5_reload_ready", 32'(a_lr), 32'(1));
    chk("t5_reload_hold", 32'(a_dout), 32'(exp_a_dout));

    // Backpressured pass of 5A bytes.
    a_pass(1, 8'h5A);
    for (int k = 0; k < 8; k++) begin
      a_read(12'($urandom), "t5_5a");
      chk("t5_5a_val", 32'(a_dout), 32'h5A);
    end

    // Random-data pass with random valid.
    a_reload = 1'b1; tick(); a_reload = 1'b0;
    a_pass(2, 8'h00);
    a_random_reads(40, "t_rand");

    // Reset in the middle of a pass.
    a_reload = 1'b1; tick(); a_reload = 1'b0;
    for (int k = 0; k < 100; k++) begin
      a_lv = 1'b1; a_ld = 8'hC3; tick();
      ref_a[k] = 8'hC3;
    end
    a_lv = 1'b0; a_reset = 1'b1;
    #2;
    chk("mid_rst_loaded", 32'(a_loaded), 32'(0));
    chk("mid_rst_dout", 32'(a_dout), 32'(0));
    exp_a_dout = 8'h00;
    tick();
    a_reset = 1'b0;
    tick();
    chk("mid_rst_ready", 32'(a_lr), 32'(1));
    a_pass(2, 8'h00);
    a_random_reads(30, "post_rst");

    // B: lane order, then out-of-range reads.
    for (int k = 0; k < int'(B_LB); k++) begin
      logic [7:0] d;
      case (k)
        0: d = 8'hAA; 1: d = 8'hBB; 2: d = 8'hCC; 3: d = 8'hDD;
        default: d = 8'($urandom);
      endcase
      b_lv = 1'b1; b_ld = d; tick();
      ref_b[k] = d;
      if (k == int'(B_LB) - 2) chk("b_not_loaded", 32'(b_loaded), 32'(0));
    end
    b_lv = 1'b0;
    chk("b_loaded", 32'(b_loaded), 32'(1));
    chk("b_word0", u_b.u_bank.mem[0], 32'hAABBCCDD);
    b_read(8'h00, "t3_l0"); chk("t3_aa", 32'(b_dout), 32'hAA);
    b_read(8'h01, "t3_l1"); chk("t3_bb", 32'(b_dout), 32'hBB);
    b_read(8'h02, "t3_l2"); chk("t3_cc", 32'(b_dout), 32'hCC);
    b_read(8'h03, "t3_l3"); chk("t3_dd", 32'(b_dout), 32'hDD);
    b_read(8'h20, "t4_oor"); chk("t4_zero", 32'(b_dout), 32'h00);
    b_read(8'h0F, "t4_last");
    b_read(8'h10, "t4_first_oor");
    for (int k = 0; k < 30; k++) b_read(8'($urandom), "b_rand");

`ifdef IPRAM_WRITE_EN
    a_we = 1'b1; a_wd = 8'h77; a_ce = 1'b1; a_addr = 12'h010;
    tick();
    a_we = 1'b0; a_ce = 1'b0;
    chk("t6_wr_dv", 32'(a_dv), 32'(0));
    chk("t6_wr_hold", 32'(a_dout), 32'(exp_a_dout));
    ref_a[16] = 8'h77;
    a_read(12'h010, "t6_rd");
    chk("t6_77", 32'(a_dout), 32'h77);
    b_we = 1'b1; b_wd = 8'h33; b_ce = 1'b1; b_addr = 8'h20;
    tick();
    b_wd = 8'h99; b_addr = 8'h05;
    tick();
    b_we = 1'b0; b_ce = 1'b0;
    ref_b[5] = 8'h99;
    b_read(8'h20, "t6_drop"); chk("t6_drop_zero", 32'(b_dout), 32'h00);
    b_read(8'h05, "t6_b5");
    b_read(8'h04, "t6_b4");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
